// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: synchronises two push-buttons (mode, speed), runs a
// speed-scaled tick prescaler and advances a ring / ping-pong / binary LED pattern.
module led_pattern_sequencer #(
    parameter int DIV_BASE = 1_000_000,
    parameter int LED_W    = 16
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             btn_mode,
    input  logic             btn_speed,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic [1:0]       speed,
    output logic             tick
);

    // Four extra bits cover the largest period, DIV_BASE << 3.
    localparam int                CNT_W   = $clog2(DIV_BASE) + 4;
    localparam logic [CNT_W-1:0]  BASE    = CNT_W'(DIV_BASE);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [LED_W-1:0]  LED_ONE = LED_W'(1);

    localparam logic [1:0] MODE_RING_L   = 2'd0;
    localparam logic [1:0] MODE_RING_R   = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_COUNT    = 2'd3;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [2:0]       mode_sync;
    logic [2:0]       speed_sync;
    logic             mode_edge;
    logic             speed_edge;

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [LED_W-1:0] led_q,   led_d;
    logic [1:0]       mode_q,  mode_d;
    logic [1:0]       speed_q, speed_d;
    dir_t             dir_q,   dir_d;
    logic             tick_q,  tick_d;

    logic [CNT_W-1:0] period_last;
    logic [LED_W-1:0] led_adv;
    dir_t             dir_adv;
    logic [1:0]       mode_inc;

    // Bit 0 is the metastability catcher; the edge is taken between bits 1 and 2.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            mode_sync  <= '0;
            speed_sync <= '0;
        end else begin
            mode_sync  <= {mode_sync[1:0], btn_mode};
            speed_sync <= {speed_sync[1:0], btn_speed};
        end
    end

    assign mode_edge   = mode_sync[1] & ~mode_sync[2];
    assign speed_edge  = speed_sync[1] & ~speed_sync[2];
    assign period_last = (BASE << speed_q) - CNT_ONE;
    assign mode_inc    = mode_q + 2'd1;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q   <= '0;
            led_q   <= LED_ONE;
            mode_q  <= MODE_RING_L;
            speed_q <= 2'd0;
            dir_q   <= DIR_LEFT;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
        end
    end

    // Pattern step for one tick; one-hot modes recover to bit 0 if corrupted.
    always_comb begin
        led_adv = led_q;
        dir_adv = dir_q;
        if (mode_q != MODE_COUNT && !$onehot(led_q)) begin
            led_adv = LED_ONE;
            dir_adv = DIR_LEFT;
        end else begin
            case (mode_q)
                MODE_RING_L: led_adv = {led_q[LED_W-2:0], led_q[LED_W-1]};
                MODE_RING_R: led_adv = {led_q[0], led_q[LED_W-1:1]};
                MODE_PINGPONG: begin
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[LED_W-1]) begin
                            dir_adv = DIR_RIGHT;
                            led_adv = led_q >> 1;
                        end else begin
                            led_adv = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_adv = DIR_LEFT;
                            led_adv = led_q << 1;
                        end else begin
                            led_adv = led_q >> 1;
                        end
                    end
                end
                default: led_adv = led_q + LED_ONE;
            endcase
        end
    end

    // Button edges take priority over the prescaler and suppress that cycle's tick.
    always_comb begin
        cnt_d   = cnt_q;
        led_d   = led_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        if (mode_edge || speed_edge) begin
            cnt_d = '0;
            if (mode_edge) begin
                mode_d = mode_inc;
                led_d  = (mode_inc == MODE_COUNT) ? '0 : LED_ONE;
                dir_d  = DIR_LEFT;
            end
            if (speed_edge) begin
                speed_d = speed_q + 2'd1;
            end
        end else if (!pause) begin
            if (cnt_q == period_last) begin
                cnt_d  = '0;
                led_d  = led_adv;
                dir_d  = dir_adv;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign speed = speed_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed testbench for led_pattern_sequencer (DIV_BASE=4, LED_W=16), with a
// small LED_W=4 instance used to reach the binary-count wrap quickly.
module tb_led_pattern_sequencer;

    logic        clk;
    logic        reset_p;
    logic        btn_mode, btn_speed, pause;
    logic [15:0] led;
    logic [1:0]  mode, speed;
    logic        tick;

    logic        btn_mode_s, btn_speed_s, pause_s;
    logic [3:0]  led_s;
    logic [1:0]  mode_s, speed_s;
    logic        tick_s;

    int total = 0;
    int bad   = 0;

    led_pattern_sequencer #(.DIV_BASE(4), .LED_W(16)) dut (
        .clk(clk), .reset_p(reset_p), .btn_mode(btn_mode), .btn_speed(btn_speed),
        .pause(pause), .led(led), .mode(mode), .speed(speed), .tick(tick)
    );

    led_pattern_sequencer #(.DIV_BASE(2), .LED_W(4)) dut_small (
        .clk(clk), .reset_p(reset_p), .btn_mode(btn_mode_s), .btn_speed(btn_speed_s),
        .pause(pause_s), .led(led_s), .mode(mode_s), .speed(speed_s), .tick(tick_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tick !== 1'b1 && n < limit);
        if (tick !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL tick_timeout: no tick within %0d clks", limit);
        end
    endtask

    task automatic press(input logic m, input logic s);
        btn_mode  = m;
        btn_speed = s;
        step(3);
        btn_mode  = 1'b0;
        btn_speed = 1'b0;
        step(3);
    endtask

    task automatic test_reset;
        #2;
        total++; if (led !== 16'h0001) begin bad++; $display("[TB] FAIL reset_led: got %h want 0001", led); end
        total++; if (mode !== 2'd0) begin bad++; $display("[TB] FAIL reset_mode: got %0d want 0", mode); end
        total++; if (speed !== 2'd0) begin bad++; $display("[TB] FAIL reset_speed: got %0d want 0", speed); end
        total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick: got %b want 0", tick); end
        step(3);
        total++; if (led !== 16'h0001 || tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_held: led %h tick %b want 0001 0", led, tick); end
        reset_p = 1'b0;
    endtask

    task automatic test_ring_left;
        logic [15:0] exp;
        int n;
        step(3);
        total++; if (tick !== 1'b0 || led !== 16'h0001) begin bad++; $display("[TB] FAIL ring_pre_tick: tick %b led %h want 0 0001", tick, led); end
        step(1);
        total++; if (tick !== 1'b1 || led !== 16'h0002) begin bad++; $display("[TB] FAIL ring_first_tick: tick %b led %h want 1 0002", tick, led); end
        step(1);
        total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL ring_tick_width: got %b want 0", tick); end
        exp = 16'h0002;
        for (int k = 2; k <= 16; k++) begin
            exp = {exp[14:0], exp[15]};
            wait_tick(20, n);
            total++; if (led !== exp) begin bad++; $display("[TB] FAIL ring_left_%0d: got %h want %h", k, led, exp); end
            total++; if (n !== ((k == 2) ? 3 : 4)) begin bad++; $display("[TB] FAIL ring_period_%0d: got %0d want 4", k, n); end
        end
    endtask

    task automatic test_speed;
        int n;
        btn_speed = 1'b1;
        step(2);
        total++; if (speed !== 2'd0) begin bad++; $display("[TB] FAIL speed_early: got %0d want 0", speed); end
        step(1);
        total++; if (speed !== 2'd1 || tick !== 1'b0) begin bad++; $display("[TB] FAIL speed_inc: speed %0d tick %b want 1 0", speed, tick); end
        btn_speed = 1'b0;
        wait_tick(40, n);
        total++; if (n !== 8) begin bad++; $display("[TB] FAIL speed1_first: got %0d want 8", n); end
        wait_tick(40, n);
        total++; if (n !== 8) begin bad++; $display("[TB] FAIL speed1_period: got %0d want 8", n); end
        press(1'b0, 1'b1);
        total++; if (speed !== 2'd2) begin bad++; $display("[TB] FAIL speed_2: got %0d want 2", speed); end
        press(1'b0, 1'b1);
        total++; if (speed !== 2'd3) begin bad++; $display("[TB] FAIL speed_3: got %0d want 3", speed); end
        press(1'b0, 1'b1);
        total++; if (speed !== 2'd0 || mode !== 2'd0) begin bad++; $display("[TB] FAIL speed_wrap: speed %0d mode %0d want 0 0", speed, mode); end
    endtask

    task automatic test_pingpong;
        logic [15:0] exp;
        int pos;
        bit going_right;
        int n;
        press(1'b1, 1'b0);
        total++; if (mode !== 2'd1) begin bad++; $display("[TB] FAIL mode_1: got %0d want 1", mode); end
        press(1'b1, 1'b0);
        total++; if (mode !== 2'd2 || led !== 16'h0001) begin bad++; $display("[TB] FAIL mode_2: mode %0d led %h want 2 0001", mode, led); end
        pos = 0;
        going_right = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            if (!going_right) begin
                if (pos == 15) begin going_right = 1'b1; pos = 14; end
                else pos++;
            end else begin
                if (pos == 0) begin going_right = 1'b0; pos = 1; end
                else pos--;
            end
            exp = 16'h0001 << pos;
            wait_tick(20, n);
            total++; if (led !== exp) begin bad++; $display("[TB] FAIL pingpong_%0d: got %h want %h", k, led, exp); end
        end
    endtask

    task automatic test_count;
        int n;
        bit found;
        press(1'b1, 1'b0);
        total++; if (mode !== 2'd3 || led !== 16'h0000) begin bad++; $display("[TB] FAIL count_load: mode %0d led %h want 3 0000", mode, led); end
        for (int k = 1; k <= 5; k++) begin
            wait_tick(20, n);
            total++; if (led !== 16'(k)) begin bad++; $display("[TB] FAIL count_%0d: got %h want %h", k, led, 16'(k)); end
        end
        for (int p = 0; p < 3; p++) begin
            btn_mode_s = 1'b1;
            step(3);
            btn_mode_s = 1'b0;
            step(3);
        end
        total++; if (mode_s !== 2'd3) begin bad++; $display("[TB] FAIL small_mode: got %0d want 3", mode_s); end
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            step(1);
            if (tick_s === 1'b1 && led_s === 4'hF) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("[TB] FAIL small_reach_f: led %h want F", led_s); end
        n = 0;
        do begin
            step(1);
            n++;
        end while (tick_s !== 1'b1 && n < 10);
        total++; if (tick_s !== 1'b1 || led_s !== 4'h0 || n !== 2) begin bad++; $display("[TB] FAIL count_wrap: led %h after %0d clks want 0 after 2", led_s, n); end
    endtask

    task automatic test_pause;
        logic [15:0] held;
        int n;
        wait_tick(20, n);
        step(2);
        held = led;
        pause = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            total++; if (led !== held || tick !== 1'b0) begin bad++; $display("[TB] FAIL pause_hold_%0d: led %h tick %b want %h 0", c, led, tick, held); end
        end
        pause = 1'b0;
        wait_tick(20, n);
        total++; if (n !== 2 || led !== held + 16'h0001) begin bad++; $display("[TB] FAIL pause_resume: %0d clks led %h want 2 %h", n, led, held + 16'h0001); end
        pause = 1'b1;
        press(1'b1, 1'b0);
        total++; if (mode !== 2'd0 || led !== 16'h0001 || tick !== 1'b0) begin bad++; $display("[TB] FAIL pause_mode: mode %0d led %h tick %b want 0 0001 0", mode, led, tick); end
        step(10);
        total++; if (led !== 16'h0001 || tick !== 1'b0) begin bad++; $display("[TB] FAIL pause_hold2: led %h tick %b want 0001 0", led, tick); end
        pause = 1'b0;
        wait_tick(20, n);
        total++; if (n !== 4 || led !== 16'h0002) begin bad++; $display("[TB] FAIL pause_resume2: %0d clks led %h want 4 0002", n, led); end
    endtask

    task automatic test_both_buttons;
        btn_mode  = 1'b1;
        btn_speed = 1'b1;
        step(2);
        total++; if (mode !== 2'd0 || speed !== 2'd0) begin bad++; $display("[TB] FAIL both_early: mode %0d speed %0d want 0 0", mode, speed); end
        step(1);
        total++; if (mode !== 2'd1 || speed !== 2'd1 || led !== 16'h0001) begin bad++; $display("[TB] FAIL both_same_clk: mode %0d speed %0d led %h want 1 1 0001", mode, speed, led); end
        btn_mode  = 1'b0;
        btn_speed = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid;
        int n;
        wait_tick(40, n);
        step(2);
        total++; if (led !== 16'h8000) begin bad++; $display("[TB] FAIL premid_led: got %h want 8000", led); end
        reset_p = 1'b1;
        #2;
        total++; if (led !== 16'h0001 || mode !== 2'd0 || speed !== 2'd0 || tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_async: led %h mode %0d speed %0d tick %b want 0001 0 0 0", led, mode, speed, tick); end
        #2;
        reset_p = 1'b0;
        wait_tick(20, n);
        total++; if (n !== 4 || led !== 16'h0002) begin bad++; $display("[TB] FAIL reset_first_tick: %0d clks led %h want 4 0002", n, led); end
    endtask

    initial begin
        reset_p     = 1'b1;
        btn_mode    = 1'b0;
        btn_speed   = 1'b0;
        pause       = 1'b0;
        btn_mode_s  = 1'b0;
        btn_speed_s = 1'b0;
        pause_s     = 1'b0;
        test_reset();
        test_ring_left();
        test_speed();
        test_pingpong();
        test_count();
        test_pause();
        test_both_buttons();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
